// File: rtl/ad9637_axil_pkg.sv
// Shared response codes, FSM state types and index sizing for the AD9637 AXI4-Lite register bank.
package ad9637_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  // Bits needed to index n registers; never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ad9637_axil_wr_ctrl.sv
// AW/W collection FSM and B channel; emits a one-cycle commit with target index, data and strobe.
// SLVERR on out-of-range or read-only targets only when AD9637_AXIL_ERR_RESP_EN is defined.
module ad9637_axil_wr_ctrl
  import ad9637_axil_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 6,
  parameter int          NUM_REGS = 8,
  parameter logic [63:0] RO_MASK  = 64'h0,
  localparam int         STRB_W   = DATA_W / 8,
  localparam int         IDX_W    = idx_width(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic              commit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [DATA_W-1:0] data_o,
  output logic [STRB_W-1:0] strb_o,
  output logic              oor_o
);

  localparam int LSB     = $clog2(STRB_W);
  localparam int FIELD_W = ADDR_W - LSB;
  localparam logic [FIELD_W:0] NREG = (FIELD_W + 1)'(NUM_REGS);

  wr_state_t           state_q, state_d;
  logic                live_q;
  logic [FIELD_W-1:0]  field_q, field_d, cur_field, aw_field;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                aw_hs, w_hs;
  logic                unused_lsb;

  assign aw_field   = awaddr_i[ADDR_W-1:LSB];
  assign unused_lsb = ^awaddr_i[LSB-1:0];

  // live_q keeps every ready low until the first edge after reset release.
  assign awready_o = live_q && (state_q == W_IDLE || state_q == W_HAVE_W);
  assign wready_o  = live_q && (state_q == W_IDLE || state_q == W_HAVE_AW);
  assign bvalid_o  = (state_q == W_RESP);
  assign bresp_o   = bresp_q;
  assign aw_hs     = awready_o && awvalid_i;
  assign w_hs      = wready_o && wvalid_i;

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    data_d    = data_q;
    strb_d    = strb_q;
    commit_o  = 1'b0;
    cur_field = field_q;
    data_o    = data_q;
    strb_o    = strb_q;
    case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit_o  = 1'b1;
          cur_field = aw_field;
          data_o    = wdata_i;
          strb_o    = wstrb_i;
          state_d   = W_RESP;
        end else if (aw_hs) begin
          field_d = aw_field;
          state_d = W_HAVE_AW;
        end else if (w_hs) begin
          data_d  = wdata_i;
          strb_d  = wstrb_i;
          state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit_o = 1'b1;
          data_o   = wdata_i;
          strb_o   = wstrb_i;
          state_d  = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit_o  = 1'b1;
          cur_field = aw_field;
          state_d   = W_RESP;
        end
      end
      W_RESP: begin
        if (bready_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // The whole field above the byte offset takes part, so stray upper bits count as out of range.
  assign oor_o = ({1'b0, cur_field} >= NREG);
  assign idx_o = cur_field[IDX_W-1:0];

`ifdef AD9637_AXIL_ERR_RESP_EN
  assign bresp_d = !commit_o ? bresp_q :
                   ((oor_o || RO_MASK[idx_o]) ? RESP_SLVERR : RESP_OKAY);
`else
  assign bresp_d = commit_o ? RESP_OKAY : bresp_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= W_IDLE;
      live_q  <= 1'b0;
      field_q <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      field_q <= field_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      bresp_q <= bresp_d;
    end
  end

endmodule

// File: rtl/ad9637_axil_regbank.sv
// Parametrised AXI4-Lite register bank: RW registers with byte strobes, RO status registers, commit pulses.
// Define AD9637_AXIL_ERR_RESP_EN to answer out-of-range accesses and RO writes with SLVERR.
module ad9637_axil_regbank
  import ad9637_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 8,
  parameter logic [63:0] RO_MASK            = 64'h00,
  localparam int         DW                 = C_S_AXI_DATA_WIDTH,
  localparam int         AW                 = C_S_AXI_ADDR_WIDTH,
  localparam int         SW                 = DW / 8
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [AW-1:0]          S_AXI_AWADDR,
  input  logic [2:0]             S_AXI_AWPROT,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [DW-1:0]          S_AXI_WDATA,
  input  logic [SW-1:0]          S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [AW-1:0]          S_AXI_ARADDR,
  input  logic [2:0]             S_AXI_ARPROT,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [DW-1:0]          S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  output logic [NUM_REGS*DW-1:0] reg_o,
  input  logic [NUM_REGS*DW-1:0] status_i,
  output logic [NUM_REGS-1:0]    wr_pulse_o
);

  localparam int LSB     = $clog2(SW);
  localparam int FIELD_W = AW - LSB;
  localparam int IDX_W   = idx_width(NUM_REGS);
  localparam logic [FIELD_W:0] NREG = (FIELD_W + 1)'(NUM_REGS);

  logic                wr_commit, wr_oor;
  logic [IDX_W-1:0]    wr_idx;
  logic [DW-1:0]       wr_data;
  logic [SW-1:0]       wr_strb;
  logic [DW-1:0]       reg_view [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_d, wr_pulse_q;
  logic                unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[LSB-1:0], status_i};

  ad9637_axil_wr_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK)
  ) u_wr_ctrl (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .awaddr_i  (S_AXI_AWADDR),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bresp_o   (S_AXI_BRESP),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .commit_o  (wr_commit),
    .idx_o     (wr_idx),
    .data_o    (wr_data),
    .strb_o    (wr_strb),
    .oor_o     (wr_oor)
  );

  // RO entries have no storage: they present the live status slice on reg_o and to reads.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_view[gi]   = status_i[gi*DW +: DW];
      assign wr_pulse_d[gi] = 1'b0;
    end else begin : g_rw
      logic [DW-1:0] reg_q;
      logic          hit;
      assign hit = wr_commit && !wr_oor && (wr_idx == IDX_W'(gi));
      always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
          reg_q <= '0;
        end else if (hit) begin
          for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) reg_q[b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
      assign reg_view[gi]   = reg_q;
      assign wr_pulse_d[gi] = hit;
    end
    assign reg_o[gi*DW +: DW] = reg_view[gi];
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) wr_pulse_q <= '0;
    else          wr_pulse_q <= wr_pulse_d;
  end
  assign wr_pulse_o = wr_pulse_q;

  rd_state_t          rd_state_q, rd_state_d;
  logic               rd_live_q, ar_hs, ar_oor;
  logic [FIELD_W-1:0] ar_field;
  logic [IDX_W-1:0]   ar_idx;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;

  assign ar_field      = S_AXI_ARADDR[AW-1:LSB];
  assign ar_oor        = ({1'b0, ar_field} >= NREG);
  assign ar_idx        = ar_field[IDX_W-1:0];
  assign S_AXI_ARREADY = rd_live_q && (rd_state_q == R_IDLE);
  assign S_AXI_RVALID  = (rd_state_q == R_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ar_hs         = S_AXI_ARREADY && S_AXI_ARVALID;

  // Capture samples reg_view before any same-edge write commit lands.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_RESP;
          rdata_d    = ar_oor ? '0 : reg_view[ar_idx];
`ifdef AD9637_AXIL_ERR_RESP_EN
          rresp_d    = ar_oor ? RESP_SLVERR : RESP_OKAY;
`else
          rresp_d    = RESP_OKAY;
`endif
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      rd_live_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_live_q  <= 1'b1;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_ad9637_axil_regbank.sv
// Scoreboard bench for ad9637_axil_regbank (NUM_REGS=8, register 7 read-only status).
module tb_ad9637_axil_regbank;

  localparam int          DW  = 32;
  localparam int          AW  = 6;
  localparam int          NR  = 8;
  localparam logic [63:0] ROM = 64'h80;
  localparam logic [1:0]  OK  = 2'b00;
`ifdef AD9637_AXIL_ERR_RESP_EN
  localparam logic [1:0]  ERR = 2'b10;
`else
  localparam logic [1:0]  ERR = 2'b00;
`endif

  logic             ACLK, ARESETN;
  logic [AW-1:0]    AWADDR, ARADDR;
  logic [2:0]       AWPROT, ARPROT;
  logic             AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic             ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0]    WDATA, RDATA;
  logic [3:0]       WSTRB;
  logic [1:0]       BRESP, RRESP;
  logic [NR*DW-1:0] reg_o, status;
  logic [NR-1:0]    wr_pulse;

  ad9637_axil_regbank #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .NUM_REGS           (NR),
    .RO_MASK            (ROM)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (AWADDR),
    .S_AXI_AWPROT  (AWPROT),
    .S_AXI_AWVALID (AWVALID),
    .S_AXI_AWREADY (AWREADY),
    .S_AXI_WDATA   (WDATA),
    .S_AXI_WSTRB   (WSTRB),
    .S_AXI_WVALID  (WVALID),
    .S_AXI_WREADY  (WREADY),
    .S_AXI_BRESP   (BRESP),
    .S_AXI_BVALID  (BVALID),
    .S_AXI_BREADY  (BREADY),
    .S_AXI_ARADDR  (ARADDR),
    .S_AXI_ARPROT  (ARPROT),
    .S_AXI_ARVALID (ARVALID),
    .S_AXI_ARREADY (ARREADY),
    .S_AXI_RDATA   (RDATA),
    .S_AXI_RRESP   (RRESP),
    .S_AXI_RVALID  (RVALID),
    .S_AXI_RREADY  (RREADY),
    .reg_o         (reg_o),
    .status_i      (status),
    .wr_pulse_o    (wr_pulse)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [1:0]  mon_b_exp;
  logic [33:0] mon_r_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slice(input int i);
    return reg_o[i*DW +: DW];
  endfunction

  // B-channel monitor: one expected response per accepted write.
  always @(negedge ACLK) begin
    if (ARESETN === 1'b1 && BVALID === 1'b1 && BREADY === 1'b1) begin
      if (bq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected: BVALID with no write outstanding");
      end else begin
        mon_b_exp = bq.pop_front();
        $display("B  resp=%0d expect=%0d", BRESP, mon_b_exp);
        check("bresp", BRESP, mon_b_exp);
      end
    end
  end

  // R-channel monitor.
  always @(negedge ACLK) begin
    if (ARESETN === 1'b1 && RVALID === 1'b1 && RREADY === 1'b1) begin
      if (rq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL r_unexpected: RVALID with no read outstanding");
      end else begin
        mon_r_exp = rq.pop_front();
        $display("R  data=%08h resp=%0d expect=%08h/%0d", RDATA, RRESP, mon_r_exp[33:2], mon_r_exp[1:0]);
        check("rdata", RDATA, mon_r_exp[33:2]);
        check("rresp", RRESP, mon_r_exp[1:0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // W is presented 'lead' cycles before AW (0 = together); returns just after the commit edge.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input logic [1:0] er);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    bq.push_back(er);
    AWADDR  = a;
    WDATA   = d;
    WSTRB   = s;
    WVALID  = 1'b1;
    AWVALID = (lead == 0);
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge ACLK);
      #1;
      if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin WVALID  = 1'b0; w_done  = 1; end
      cyc++;
      if (!aw_done && cyc >= lead) AWVALID = 1'b1;
    end
    if (!(aw_done && w_done)) begin
      n_vec++;
      n_err++;
      $display("FAIL write_timeout: addr %0h not accepted within 50 cycles", a);
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] ed, input logic [1:0] er);
    int cyc = 0;
    bit done = 0, hs;
    rq.push_back({ed, er});
    ARADDR  = a;
    ARVALID = 1'b1;
    while (!done && cyc < 50) begin
      @(negedge ACLK);
      hs = ARVALID && ARREADY;
      @(posedge ACLK);
      #1;
      if (hs) begin ARVALID = 1'b0; done = 1; end
      cyc++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL read_timeout: addr %0h not accepted within 50 cycles", a);
      ARVALID = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    WDATA = '0; WSTRB = '0;
    BREADY = 1'b1; RREADY = 1'b1;
    for (int i = 0; i < NR; i++) status[i*DW +: DW] = 32'hA5A50000 + i;
    status[7*DW +: DW] = 32'hDEADBEEF;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_pulse", wr_pulse, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_reg0", slice(0), 0);
    @(posedge ACLK); #1; ARESETN = 1'b1;
    @(negedge ACLK);
    check("rel_awready_low", AWREADY, 0);
    @(negedge ACLK);
    check("rel_awready", AWREADY, 1);
    check("rel_wready", WREADY, 1);
    check("rel_arready", ARREADY, 1);
    idle(1);

    // Basic writes and readback
    axi_write(6'h00, 32'h11223344, 4'hF, 0, OK);
    axi_write(6'h04, 32'h55667788, 4'hF, 0, OK);
    idle(1);
    check("reg0", slice(0), 32'h11223344);
    check("reg1", slice(1), 32'h55667788);
    axi_read(6'h00, 32'h11223344, OK);
    axi_read(6'h04, 32'h55667788, OK);

    // Byte strobes with W leading AW
    axi_write(6'h08, 32'h11111111, 4'hF, 0, OK);
    idle(2);
    axi_write(6'h08, 32'hAABBCCDD, 4'b0101, 3, OK);
    check("pulse_r2", wr_pulse, 8'h04);
    check("reg2_strb", slice(2), 32'h11BB11DD);
    idle(1);
    check("pulse_r2_off", wr_pulse, 8'h00);
    axi_write(6'h08, 32'hFFFFFFFF, 4'b0000, 0, OK);
    check("pulse_zero_strb", wr_pulse, 8'h04);
    check("reg2_zero_strb", slice(2), 32'h11BB11DD);

    // Read-only status register
    axi_read(6'h1C, 32'hDEADBEEF, OK);
    axi_write(6'h1C, 32'h01234567, 4'hF, 0, ERR);
    check("ro_no_pulse", wr_pulse, 8'h00);
    check("ro_reg7", slice(7), 32'hDEADBEEF);
    axi_read(6'h1C, 32'hDEADBEEF, OK);

    // Out-of-range read with RREADY held low
    idle(2);
    RREADY = 1'b0;
    axi_read(6'h20, 32'h0, ERR);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("r_hold_valid", RVALID, 1);
      check("r_hold_data", RDATA, 0);
      check("r_hold_resp", RRESP, ERR);
    end
    @(posedge ACLK); #1; RREADY = 1'b1;
    idle(2);
    RREADY = 1'b0;
    axi_read(6'h04, 32'h55667788, OK);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      check("r_hold_data_nz", RDATA, 32'h55667788);
    end
    @(posedge ACLK); #1; RREADY = 1'b1;
    idle(2);

    // Out-of-range write with BREADY held low
    BREADY = 1'b0;
    axi_write(6'h20, 32'h99999999, 4'hF, 0, ERR);
    check("oor_no_pulse", wr_pulse, 8'h00);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("b_hold_valid", BVALID, 1);
      check("b_hold_resp", BRESP, ERR);
    end
    @(posedge ACLK); #1; BREADY = 1'b1;
    idle(2);

    // Write and read of the same register accepted on the same edge
    axi_write(6'h0C, 32'h12345678, 4'hF, 0, OK);
    idle(2);
    fork
      axi_write(6'h0C, 32'hCAFEF00D, 4'hF, 0, OK);
      axi_read(6'h0C, 32'h12345678, OK);
    join
    axi_read(6'h0C, 32'hCAFEF00D, OK);

    // Reset while waiting for W
    idle(3);
    AWADDR = 6'h10;
    AWVALID = 1'b1;
    @(negedge ACLK);
    check("aw_only_ready", AWREADY, 1);
    @(posedge ACLK); #1; AWVALID = 1'b0;
    @(negedge ACLK);
    check("have_aw_awready", AWREADY, 0);
    check("have_aw_wready", WREADY, 1);
    ARESETN = 1'b0;
    @(posedge ACLK); #1; ARESETN = 1'b1;
    @(negedge ACLK);
    check("mid_rst_bvalid", BVALID, 0);
    check("mid_rst_awready", AWREADY, 0);
    for (int i = 0; i < NR - 1; i++) check("mid_rst_reg", slice(i), 0);
    check("mid_rst_reg7", slice(7), 32'hDEADBEEF);
    @(negedge ACLK);
    check("post_rst_awready", AWREADY, 1);
    check("post_rst_bvalid", BVALID, 0);
    idle(1);
    axi_write(6'h04, 32'h0BADF00D, 4'hF, 0, OK);
    axi_read(6'h04, 32'h0BADF00D, OK);
    axi_read(6'h00, 32'h0, OK);

    idle(4);
    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad9637_axil_regbank.md
# ad9637_axil_regbank

Parametrised AXI4-Lite slave register bank for the AD9637 capture IP, replacing the fixed four-register slave in the IP shell. It provides NUM_REGS 32-bit-addressed registers with byte-lane write strobes, a configurable set of read-only status registers fed from the capture datapath, per-register write-commit pulses, and optional error responses. It sits between the AXI interconnect and the ADC interface control logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6: address port width; must be ≥ clog2(NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8).
- NUM_REGS, 8: register count, 2..64.
- RO_MASK, 'h00: bit i set means register i is read-only and reads status_i slice i.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; one clock, synchronous, active-low.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  AXI4-Lite AW channel; AWPROT is ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  W channel; WSTRB width is DATA_WIDTH/8.
- S_AXI_BRESP/BVALID/BREADY  B channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  AR channel; ARPROT is ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  R channel.
- reg_o  out  NUM_REGS*DATA_W  flattened register contents; slice i = register i.
- status_i  in  NUM_REGS*DATA_W  values for read-only registers; slices for RW registers are unused.
- wr_pulse_o  out  NUM_REGS  one-cycle commit strobe per register.

## Operation
- Register index = addr[ADDR_W-1 : LSB], with LSB = clog2(DATA_W/8). Low LSB address bits are ignored.
- Out of range: index ≥ NUM_REGS, or any nonzero address bit above the index field.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: AWREADY=1, WREADY=1.
  - Both AW and W handshake in the same cycle: commit, then go to W_RESP.
  - AW only: latch address, go to W_HAVE_AW (AWREADY=0, WREADY=1).
  - W only: latch data and strobe, go to W_HAVE_W (WREADY=0, AWREADY=1).
  - W_HAVE_AW / W_HAVE_W: on the missing handshake, commit and go to W_RESP.
  - W_RESP: BVALID=1, both readies 0. On BREADY go to W_IDLE.
- Commit: for each byte with WSTRB set, update that byte of the target RW register. wr_pulse_o[idx]=1 for one cycle, even if WSTRB=0. Writes to RO or out-of-range addresses change nothing and raise no pulse.
- Read FSM states: R_IDLE (ARREADY=1), R_RESP (RVALID=1, ARREADY=0). On AR handshake, RDATA is captured from the register or status_i. On RREADY, return to R_IDLE.
- Read and write FSMs are independent. A read accepted in the same cycle as a write commit to the same register returns the pre-write value.
- Out-of-range read returns RDATA=0.

## Timing
- Reset (ARESETN=0 at a clock edge) clears:
  - all readies, BVALID, RVALID, wr_pulse_o;
  - RDATA, BRESP, RRESP (to 0);
  - all RW registers (to 0).
  - AWREADY, WREADY and ARREADY rise on the first edge after release.
- Reset mid-transaction abandons it; no response is issued.
- Write latency: BVALID is asserted on the cycle after the final handshake. reg_o and wr_pulse_o update on that same edge.
- Read latency: RVALID and RDATA are valid one cycle after the AR handshake.
- BVALID/BRESP and RVALID/RDATA/RRESP are held stable until accepted.
- Throughput: one write per 2 cycles with BREADY tied high; one read per 2 cycles.

## Configuration
- AD9637_AXIL_ERR_RESP_EN defined:
  - out-of-range read/write → RESP=2'b10 (SLVERR);
  - write to an RO register → SLVERR.
- Not defined: every response is OKAY (2'b00). Data behaviour is identical in both cases.

## Structure
- Package ad9637_axil_pkg holds:
  - RESP_OKAY and RESP_SLVERR constants;
  - the wr_state_t and rd_state_t enums;
  - the index-width helper function.
- One sub-module, ad9637_axil_wr_ctrl: AW/W collection FSM and B channel. It outputs the commit strobe, index, data, strobe and range flag. The register array and read path stay in the top module.

## Test plan
- Defaults: write 0x11223344 to 0x00, 0x55667788 to 0x04 (AW and W together, BREADY=1) → BRESP=0, reg_o slice0/1 match; readback returns the same values with RRESP=0.
- W issued 3 cycles before AW to 0x08, WSTRB=4'b0101, data 0xAABBCCDD, over prior 0x11111111 → reg 2 = 0x11BB11DD. wr_pulse_o[2] high for exactly one cycle.
- RO_MASK='h80, status_i slice7=0xDEADBEEF: read 0x1C → 0xDEADBEEF. Write 0x1C → register unchanged, no pulse; BRESP=2'b10 with the macro, 0 without.
- Read 0x20 (out of range for NUM_REGS=8) → RDATA=0, RRESP=2'b10 with the macro, 0 without. BREADY/RREADY held low for 5 cycles → valid and data held stable throughout.
- Write 0x0C and read 0x0C accepted in the same cycle → read returns the old value; the next read returns the new value.
- ARESETN low for 1 cycle during W_HAVE_AW → no BVALID, all registers 0, AWREADY=1 on the next edge; a subsequent full write succeeds.
